ctrl_regs_bank: RTL
===================

Name: ctrl_regs_bank

Overview:
Parametrised control-register bank that generalises the board's per-channel FPGA control registers. It holds N_CH byte-wide registers, each written from the shared master byte stream when its channel's valid strobe fires. Each register has a per-register reset value and per-bit self-clearing pulse bits with a programmable pulse length. After every write, each channel returns a one-byte readback message through the standard have_msg/rdreq/len slave interface. The block sits on the same master/slave channel fabric as the other slave blocks; its register outputs drive board control pins such as power enables, mux address, reset and standby.

Parameters:
- N_CH, 10, number of channels/registers (1..16)
- RST_VAL, {N_CH{8'h00}}, N_CH*8-bit vector; byte i is the reset value of register i
- PULSE_MASK, {N_CH{8'h00}}, N_CH*8-bit vector; a set bit marks a self-clearing pulse bit
- PULSE_LEN, 16, cycles a pulse bit stays asserted after a write (1..65535)

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset; asynchronous, active-low
- master_data  in  8  write byte shared by all channels
- valid_bus  in  N_CH  per-channel write strobe, one cycle per byte
- rdreq_bus  in  N_CH  per-channel readback pop
- have_msg_bus  out  N_CH  readback byte pending
- slave_data_bus  out  N_CH*8  byte i is the readback data of channel i
- len_bus  out  N_CH*8  byte i is the pending message length of channel i (0 or 1)
- regs_out  out  N_CH*8  byte i is the current value of register i

Behaviour:
Reset (async assert, sync release):
- reg[i] = RST_VAL[i]
- pending[i] = 0
- pulse counters = 0
- All outputs follow from these values.

Write:
- valid_bus[i] high at a rising edge → reg[i] <= master_data at that edge. regs_out is updated in the following cycle (1-cycle latency).
- Several valid bits high in the same cycle → every strobed register takes the same byte.
- master_data is ignored when valid_bus is all zero.

Pulse bits:
- Any write to reg[i] whose masked bits (master_data & PULSE_MASK[i]) are nonzero loads cnt[i] <= PULSE_LEN.
- While cnt[i] > 0 it decrements each cycle.
- At the edge where cnt[i] goes 1→0, the pulse bits of reg[i] revert to their RST_VAL bits. Non-pulse bits are untouched.
- Net effect: a pulse bit written to 1 is visible for exactly PULSE_LEN cycles.
- A rewrite during an active pulse reloads the counter (retrigger) and takes the new data.
- A write with all masked bits 0 clears the pulse bits immediately and forces cnt[i] <= 0.
- Write and expiry on the same edge → the write wins.

Readback (per channel, independent):
- A write to channel i sets pending[i].
- have_msg_bus[i] = pending[i].
- len_bus byte i = pending[i] ? 8'd1 : 8'd0.
- slave_data_bus byte i = the live reg[i] value, so it reflects pulse expiry.
- rdreq_bus[i] while pending[i] → pending[i] cleared at that edge.
- rdreq_bus[i] with pending[i]=0 → ignored; no error and no state change.
- valid_bus[i] and rdreq_bus[i] in the same cycle → pending stays 1 and the register takes the new byte.
- At most one pending message per channel. Further writes overwrite it; there is no queue.

Counter sizing:
- Counter width = clog2(PULSE_LEN+1).
- PULSE_LEN outside 1..65535 or N_CH outside 1..16 → elaboration error.

Decomposition:
- Shared package: clog2 function, default N_CH, and byte-width constant 8.
- One sub-module, ctrl_reg_ch, holding a single channel (register, pulse counter, pending flag) with parameters RST and MASK (8 bits each) and PULSE_LEN.
- The top level instantiates ctrl_reg_ch N_CH times via generate and slices the buses.

Test Plan:
1. Reset with RST_VAL byte 7 = 8'h01, byte 8 = 8'h01, others 0 → regs_out matches RST_VAL, have_msg_bus=0, len_bus=0.
2. valid_bus=10'h001 with master_data=8'h0A → regs_out byte 0 = 8'h0A the next cycle, have_msg_bus[0]=1, len byte 0=1, slave_data byte 0=8'h0A. Then rdreq_bus[0]=1 → have_msg_bus[0]=0.
3. PULSE_MASK byte 9=8'h01, PULSE_LEN=16, write 8'h03 to channel 9 → bit0 high for exactly 16 cycles then 0, bit1 stays 1, slave_data byte 9 goes 8'h03→8'h02.
4. Retrigger: write 8'h01 to channel 9, write again 10 cycles later → bit0 high 26 cycles total. Writing 8'h00 mid-pulse clears bit0 the next cycle.
5. valid_bus=10'h3FF with data 8'h55 → all registers 8'h55 and all have_msg high. rdreq on channel 3 only → only have_msg_bus[3] clears.
6. Simultaneous valid_bus[2] and rdreq_bus[2] → have_msg_bus[2] stays 1 with the new data. Asserting n_rst mid-pulse → immediate return to RST_VAL with all counters 0.

Source files
------------

// File: rtl/ctrl_regs_bank_pkg.sv
// Shared constants and helpers for the control-register bank.
package ctrl_regs_bank_pkg;

  // Every register and every readback or length field is one byte wide.
  localparam int BYTE_W = 8;

  // Default channel count, matching the board's control-register map.
  localparam int N_CH_DEFAULT = 10;

  // Ceiling log2. Used to size a counter that has to hold values 0..N-1,
  // so a counter that must reach PULSE_LEN is sized with clog2(PULSE_LEN+1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ctrl_reg_ch.sv
// One control-register channel. It holds the register byte, a counter that
// times the self-clearing pulse bits, and a flag that marks a pending
// one-byte readback message.
module ctrl_reg_ch
  import ctrl_regs_bank_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RST       = '0,
  parameter logic [BYTE_W-1:0] MASK      = '0,
  parameter int                PULSE_LEN = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rdreq,
  output logic [BYTE_W-1:0] value,
  output logic              pending
);

  localparam int CW = clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [BYTE_W-1:0] value_reg, value_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              pending_reg, pending_next;

  // A write takes priority over a pulse expiring on the same edge. A write
  // with any pulse bit set (re)starts the timer; one with none cancels it.
  // A write and a pop in the same cycle leave the message pending.
  always_comb begin
    value_next   = value_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;

    if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CNT_ONE;
      if (cnt_reg == CNT_ONE) begin
        value_next = (value_reg & ~MASK) | (RST & MASK);
      end
    end

    if (wr_en) begin
      value_next   = wr_data;
      cnt_next     = ((wr_data & MASK) != '0) ? CNT_LOAD : '0;
      pending_next = 1'b1;
    end else if (rdreq) begin
      pending_next = 1'b0;
    end
  end

  // Channel state, returned to its reset values asynchronously.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value_reg   <= RST;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      value_reg   <= value_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
    end
  end

  assign value   = value_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/ctrl_regs_bank.sv
// Bank of N_CH byte-wide control registers on the shared master/slave
// channel fabric. Each channel is written from the common master byte and
// answers every write with a one-byte readback of its live register value.
module ctrl_regs_bank
  import ctrl_regs_bank_pkg::*;
#(
  parameter int                     N_CH       = N_CH_DEFAULT,
  parameter logic [N_CH*BYTE_W-1:0] RST_VAL    = '0,
  parameter logic [N_CH*BYTE_W-1:0] PULSE_MASK = '0,
  parameter int                     PULSE_LEN  = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [BYTE_W-1:0]        master_data,
  input  logic [N_CH-1:0]          valid_bus,
  input  logic [N_CH-1:0]          rdreq_bus,
  output logic [N_CH-1:0]          have_msg_bus,
  output logic [N_CH*BYTE_W-1:0]   slave_data_bus,
  output logic [N_CH*BYTE_W-1:0]   len_bus,
  output logic [N_CH*BYTE_W-1:0]   regs_out
);

  // Reject parameter values the channel fabric and counters cannot support.
  generate
    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
      $error("ctrl_regs_bank: N_CH must be in 1..16");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > 65535) begin : g_bad_pulse_len
      $error("ctrl_regs_bank: PULSE_LEN must be in 1..65535");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
      logic [BYTE_W-1:0] ch_value;
      logic              ch_pending;

      ctrl_reg_ch #(
        .RST       (RST_VAL[gi*BYTE_W +: BYTE_W]),
        .MASK      (PULSE_MASK[gi*BYTE_W +: BYTE_W]),
        .PULSE_LEN (PULSE_LEN)
      ) u_ch (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (valid_bus[gi]),
        .wr_data (master_data),
        .rdreq   (rdreq_bus[gi]),
        .value   (ch_value),
        .pending (ch_pending)
      );

      // The readback carries the live register, so it also shows pulse expiry.
      assign regs_out[gi*BYTE_W +: BYTE_W]       = ch_value;
      assign slave_data_bus[gi*BYTE_W +: BYTE_W] = ch_value;
      assign len_bus[gi*BYTE_W +: BYTE_W]        = ch_pending ? BYTE_W'(1) : '0;
      assign have_msg_bus[gi]                    = ch_pending;
    end
  endgenerate

endmodule
